// File: rtl/input_conditioner.sv
// Purpose: synchronize, debounce and edge-detect raw panel buttons/switches into clean one-clock events.
// Latency: button press -> btn_pulse after DEBOUNCE_CYCLES+3 clocks; level switches settle after DEBOUNCE_CYCLES+2.
// Backpressure: none; coincident presses queue in a pending mask and drain one per clock, highest index first.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic [3:0] sw,
    input  logic       plKey,
    input  logic       setNo,
    input  logic       enable,
    output logic [3:0] btn_pulse,
    output logic [3:0] sw_cap,
    output logic       plkey_db,
    output logic       setno_db,
    output logic       enable_db
);

    // Channel map: [3:0] buttons, [4] player key, [5] set number, [6] game enable.
    localparam int NCH = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync_meta;
    logic [NCH-1:0]   sync_q;
    logic [3:0]       sw_meta;
    logic [3:0]       sw_sync;
    logic [NCH-1:0]   stable;
    logic [CNT_W-1:0] cnt [NCH];
    logic [NCH-1:0]   accept;
    logic [3:0]       btn_rise;
    logic [3:0]       pending;
    logic [3:0]       pending_nxt;
    logic [3:0]       grant;
    logic             issue;

    assign raw = {enable, setNo, plKey, btn};

    // Two-flop synchronizers for every raw input; sw is synchronized but not debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
        end
    end

    // A channel accepts its new level on the clock its counter has seen DEBOUNCE_CYCLES-1 disagreeing clocks.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NCH; i++) begin
            accept[i] = (sync_q[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Debounce counters: any agreement with the stable level restarts the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_q[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync_q[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign plkey_db  = stable[4];
    assign setno_db  = stable[5];
    assign enable_db = stable[6];

    // Only a 0->1 acceptance is a press; releases are ignored.
    assign btn_rise = accept[3:0] & sync_q[3:0];
    assign issue    = enable_db && (pending != 4'b0000);

    // Pick the highest pending button and work out the next pending mask; a new press wins over a same-bit clear.
    always_comb begin
        grant = 4'b0000;
        if (pending[3]) begin
            grant = 4'b1000;
        end else if (pending[2]) begin
            grant = 4'b0100;
        end else if (pending[1]) begin
            grant = 4'b0010;
        end else if (pending[0]) begin
            grant = 4'b0001;
        end

        pending_nxt = 4'b0000;
        if (enable_db) begin
            pending_nxt = (pending & ~grant) | btn_rise;
        end
    end

    // Pending mask plus registered pulse/capture outputs; sw_cap holds between events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            btn_pulse <= '0;
            sw_cap    <= '0;
        end else begin
            pending <= pending_nxt;
            if (issue) begin
                btn_pulse <= grant;
                sw_cap    <= sw_sync;
            end else begin
                btn_pulse <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short debounce window.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Timing references count rising edges after the input change.
module tb_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] sw;
    logic       plKey;
    logic       setNo;
    logic       enable;
    logic [3:0] btn_pulse;
    logic [3:0] sw_cap;
    logic       plkey_db;
    logic       setno_db;
    logic       enable_db;

    int passed = 0;
    int total  = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .sw       (sw),
        .plKey    (plKey),
        .setNo    (setNo),
        .enable   (enable),
        .btn_pulse(btn_pulse),
        .sw_cap   (sw_cap),
        .plkey_db (plkey_db),
        .setno_db (setno_db),
        .enable_db(enable_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 4'h0; sw = 4'h0; plKey = 1'b0; setNo = 1'b0; enable = 1'b0;
        tick(3);
        total++; if (btn_pulse !== 4'b0000) $display("FAIL reset_btn_pulse got %b want 0000", btn_pulse); else passed++;
        total++; if (sw_cap !== 4'h0) $display("FAIL reset_sw_cap got %h want 0", sw_cap); else passed++;
        total++; if (plkey_db !== 1'b0) $display("FAIL reset_plkey_db got %b want 0", plkey_db); else passed++;
        total++; if (setno_db !== 1'b0) $display("FAIL reset_setno_db got %b want 0", setno_db); else passed++;
        total++; if (enable_db !== 1'b0) $display("FAIL reset_enable_db got %b want 0", enable_db); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_enable_up();
        enable = 1'b1;
        tick(5);
        total++; if (enable_db !== 1'b0) $display("FAIL enable_early got %b want 0", enable_db); else passed++;
        tick(1);
        total++; if (enable_db !== 1'b1) $display("FAIL enable_accept got %b want 1", enable_db); else passed++;
        tick(4);
    endtask

    task automatic test_single_press();
        sw  = 4'h9;
        btn = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 7) begin
                total++; if (btn_pulse !== 4'b0100) $display("FAIL single_pulse t=%0d got %b want 0100", k, btn_pulse); else passed++;
                total++; if (sw_cap !== 4'h9) $display("FAIL single_sw_cap got %h want 9", sw_cap); else passed++;
            end else begin
                total++; if (btn_pulse !== 4'b0000) $display("FAIL single_quiet t=%0d got %b want 0000", k, btn_pulse); else passed++;
            end
        end
        btn = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            total++; if (btn_pulse !== 4'b0000) $display("FAIL release_quiet t=%0d got %b want 0000", k, btn_pulse); else passed++;
        end
        total++; if (sw_cap !== 4'h9) $display("FAIL sw_cap_hold got %h want 9", sw_cap); else passed++;
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 4; g++) begin
            btn = (g % 2 == 0) ? 4'b0001 : 4'b0000;
            for (int k = 0; k < 2; k++) begin
                tick(1);
                total++; if (btn_pulse !== 4'b0000) $display("FAIL glitch_quiet g=%0d got %b want 0000", g, btn_pulse); else passed++;
            end
        end
        btn = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 7) begin
                total++; if (btn_pulse !== 4'b0001) $display("FAIL glitch_pulse t=%0d got %b want 0001", k, btn_pulse); else passed++;
            end else begin
                total++; if (btn_pulse !== 4'b0000) $display("FAIL glitch_other t=%0d got %b want 0000", k, btn_pulse); else passed++;
            end
        end
        btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_p;
        logic [3:0] exp_s;
        sw  = 4'h3;
        btn = 4'b1011;
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            if (k == 5) sw = 4'hA;
            if (k == 6) sw = 4'hB;
            exp_p = 4'b0000;
            exp_s = 4'h0;
            case (k)
                7: begin exp_p = 4'b1000; exp_s = 4'h3; end
                8: begin exp_p = 4'b0010; exp_s = 4'hA; end
                9: begin exp_p = 4'b0001; exp_s = 4'hB; end
                default: ;
            endcase
            total++; if (btn_pulse !== exp_p) $display("FAIL b2b_pulse t=%0d got %b want %b", k, btn_pulse, exp_p); else passed++;
            if (k >= 7 && k <= 9) begin
                total++; if (sw_cap !== exp_s) $display("FAIL b2b_sw_cap t=%0d got %h want %h", k, sw_cap, exp_s); else passed++;
            end
        end
        btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_enable_gate();
        enable = 1'b0;
        tick(8);
        total++; if (enable_db !== 1'b0) $display("FAIL gate_enable_low got %b want 0", enable_db); else passed++;
        btn = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            total++; if (btn_pulse !== 4'b0000) $display("FAIL gate_disabled t=%0d got %b want 0000", k, btn_pulse); else passed++;
        end
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            total++; if (btn_pulse !== 4'b0000) $display("FAIL gate_stale t=%0d got %b want 0000", k, btn_pulse); else passed++;
        end
        total++; if (enable_db !== 1'b1) $display("FAIL gate_enable_high got %b want 1", enable_db); else passed++;
        btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_reset_mid();
        sw  = 4'h5;
        btn = 4'b1111;
        tick(7);
        total++; if (btn_pulse !== 4'b1000) $display("FAIL rstmid_first got %b want 1000", btn_pulse); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (btn_pulse !== 4'b0000) $display("FAIL rstmid_async_pulse got %b want 0000", btn_pulse); else passed++;
        total++; if (sw_cap !== 4'h0) $display("FAIL rstmid_async_sw_cap got %h want 0", sw_cap); else passed++;
        total++; if (enable_db !== 1'b0) $display("FAIL rstmid_async_enable got %b want 0", enable_db); else passed++;
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            total++; if (btn_pulse !== 4'b0000) $display("FAIL rstmid_no_pulse t=%0d got %b want 0000", k, btn_pulse); else passed++;
            if (k == 5) begin
                total++; if (enable_db !== 1'b0) $display("FAIL rstmid_enable_early got %b want 0", enable_db); else passed++;
            end
            if (k == 6) begin
                total++; if (enable_db !== 1'b1) $display("FAIL rstmid_enable_accept got %b want 1", enable_db); else passed++;
            end
        end
        btn = 4'b0000;
        tick(10);
        btn = 4'b0010;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            if (k == 7) begin
                total++; if (btn_pulse !== 4'b0010) $display("FAIL rstmid_fresh t=%0d got %b want 0010", k, btn_pulse); else passed++;
                total++; if (sw_cap !== 4'h5) $display("FAIL rstmid_fresh_sw got %h want 5", sw_cap); else passed++;
            end else begin
                total++; if (btn_pulse !== 4'b0000) $display("FAIL rstmid_fresh_quiet t=%0d got %b want 0000", k, btn_pulse); else passed++;
            end
        end
        btn = 4'b0000;
        tick(10);
    endtask

    task automatic test_levels();
        plKey = 1'b1;
        tick(3);
        plKey = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            total++; if (plkey_db !== 1'b0) $display("FAIL plkey_short t=%0d got %b want 0", k, plkey_db); else passed++;
        end
        plKey = 1'b1;
        setNo = 1'b1;
        tick(5);
        total++; if (plkey_db !== 1'b0) $display("FAIL plkey_early got %b want 0", plkey_db); else passed++;
        total++; if (setno_db !== 1'b0) $display("FAIL setno_early got %b want 0", setno_db); else passed++;
        tick(1);
        total++; if (plkey_db !== 1'b1) $display("FAIL plkey_accept got %b want 1", plkey_db); else passed++;
        total++; if (setno_db !== 1'b1) $display("FAIL setno_accept got %b want 1", setno_db); else passed++;
        total++; if (btn_pulse !== 4'b0000) $display("FAIL levels_no_pulse got %b want 0000", btn_pulse); else passed++;
    endtask

    initial begin
        test_reset();
        test_enable_up();
        test_single_press();
        test_glitch();
        test_back_to_back();
        test_enable_gate();
        test_reset_mid();
        test_levels();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
